// File: rtl/ft_tx_scheduler.sv
// Round-robin scheduler that frames per-source payloads into the FT600 TX FIFO.
// Each packet is one header word followed by len payload words and a one-cycle gap.
module ft_tx_scheduler #(
  parameter int         NSRC    = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_req,
  input  logic [8*NSRC-1:0]    src_len,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [16*NSRC-1:0]   src_data,
  output logic [NSRC-1:0]      src_pop,
  output logic [NSRC-1:0]      grant,
  output logic                 tx_en,
  output logic [15:0]          tx_in,
  input  logic                 tx_full,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  win_idx, last, arb_idx;
  logic [7:0]  len_q, remaining, arb_len;
  logic        arb_found, sel_valid;
  logic [15:0] sel_data;
  int          cand;

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = (int'(last) + k) % NSRC;
      if (!arb_found && src_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = 3'(cand);
      end
    end
    arb_len   = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (arb_idx == 3'(i))
        arb_len = src_len[8*i +: 8];
      if (win_idx == 3'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NSRC; i++)
      grant[i] = ((state == HDR) || (state == DATA)) && (win_idx == 3'(i));
  end

  always_comb begin
    state_nxt = state;
    tx_en     = 1'b0;
    tx_in     = '0;
    src_pop   = '0;
    case (state)
      IDLE: begin
        if (arb_found)
          state_nxt = HDR;
      end
      HDR: begin
        tx_in = {HDR_TAG, 1'b0, win_idx, len_q};
        tx_en = ~tx_full;
        if (tx_en)
          state_nxt = (len_q != 8'd0) ? DATA : GAP;
      end
      DATA: begin
        tx_in = sel_data;
        tx_en = sel_valid & ~tx_full;
        if (tx_en && (remaining == 8'd1))
          state_nxt = GAP;
      end
      GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Writes and pops are suppressed while reset is being applied.
    if (!rst_n)
      tx_en = 1'b0;
    for (int i = 0; i < NSRC; i++)
      src_pop[i] = tx_en && (state == DATA) && (win_idx == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_idx   <= '0;
      len_q     <= '0;
      remaining <= '0;
      last      <= 3'(NSRC - 1);
      pkt_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_found) begin
            win_idx <= arb_idx;
            len_q   <= arb_len;
          end
        end
        HDR:  if (tx_en) remaining <= len_q;
        DATA: if (tx_en) remaining <= remaining - 8'd1;
        GAP: begin
          pkt_count <= pkt_count + 16'd1;
          last      <= win_idx;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/ft_tx_scheduler.md
FT_TX_SCHEDULER -- requirements
Module: ft_tx_scheduler

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter HDR_TAG, default 4'hA, upper nibble of every header word.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port src_req  input  NSRC  per-source packet request, held until granted.
REQ-006 SHALL have port src_len  input  8*NSRC  per-source payload length in words, slice i = [8i+7:8i], stable while src_req[i]=1.
REQ-007 SHALL have port src_valid  input  NSRC  per-source payload word available.
REQ-008 SHALL have port src_data  input  16*NSRC  per-source payload word, slice i = [16i+15:16i].
REQ-009 SHALL have port src_pop  output  NSRC  one-hot, payload word consumed this cycle.
REQ-010 SHALL have port grant  output  NSRC  one-hot, source owning the TX path, else 0.
REQ-011 SHALL have port tx_en  output  1  write strobe into the FT600 TX FIFO.
REQ-012 SHALL have port tx_in  output  16  word written into the TX FIFO.
REQ-013 SHALL have port tx_full  input  1  TX FIFO full; no write may occur while high.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port pkt_count  output  16  count of completed packets.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA, GAP.
REQ-017 SHALL in IDLE, if any src_req bit is high, select the winner round-robin starting at index (last+1) mod NSRC, latch its index and src_len, set grant, go to HDR. last = index of most recent winner; reset value NSRC-1.
REQ-018 SHALL in HDR drive tx_in = {HDR_TAG, 1'b0, winner index[2:0], latched len[7:0]} and tx_en = ~tx_full; on a write, go to DATA if len != 0, else to GAP.
REQ-019 SHALL in DATA drive tx_in = winner's src_data slice and tx_en = src_valid[winner] & ~tx_full, with src_pop[winner] = tx_en; this is combinational, zero latency.
REQ-020 SHALL in DATA decrement the remaining count on each write and go to GAP on the write that takes the count to 0.
REQ-021 SHALL in DATA hold state with no write while src_valid[winner]=0 or tx_full=1, with no timeout.
REQ-022 SHALL in GAP, for exactly one cycle, clear grant, increment pkt_count (mod 2^16, wraps at 16'hFFFF -> 0), update last, and return to IDLE.
REQ-023 SHALL ignore src_req of the winner during GAP; the earliest re-grant of any source is the cycle after GAP.
REQ-024 SHALL keep tx_en=0 and src_pop=0 in IDLE and GAP, keep tx_in=0 in IDLE and GAP, and never assert tx_en in a cycle where tx_full=1.
REQ-025 SHALL drive src_pop bits of non-winning sources to 0 in every state.
REQ-026 SHALL give a length of 255 exactly 256 TX writes: the header plus 255 payload words.

Reset
REQ-027 SHALL, on a clk edge with rst_n=0, go to IDLE and clear grant, busy, pkt_count, and the remaining count, with last = NSRC-1; this overrides any in-progress packet.
REQ-028 SHALL hold tx_en=0 and src_pop=0 combinationally during any cycle in which rst_n=0.
REQ-029 SHALL, after a mid-packet reset, not emit the remainder of the aborted packet; the next packet starts with a fresh header.

Verification
REQ-030 Single request: src_req=4'b0010, len=3, valid=1, tx_full=0 -> tx writes A103, d0, d1, d2 on consecutive cycles; then GAP; pkt_count=1.
REQ-031 Round-robin: src_req=4'b1111 held, len=1 each -> headers in source order 0,1,2,3,0 (A001, A101, A201, A301, A001).
REQ-032 Backpressure: tx_full=1 for 5 cycles mid-DATA -> tx_en=0 and src_pop=0 for those cycles; no word lost or duplicated; order preserved.
REQ-033 Source stall plus zero length: src_valid low 3 cycles in DATA -> hold, no writes. Separately, len=0 on source 2 -> header A200 only, then GAP.
REQ-034 Reset mid-packet: rst_n=0 after 2 of 8 payload words -> next cycle busy=0, grant=0, pkt_count=0. A new request then starts with a header, and arbitration begins from source 0.
REQ-035 Wrap: force pkt_count to 16'hFFFF, complete one packet -> pkt_count=0.
